ddr_note_field: RTL and testbench

- Parametrised playfield for the DDR game: a LANES-wide, ROWS-deep grid of arrow lights that scrolls one row per game tick.
- Notes enter at the top row and fall toward the bottom, which is the hit row. Player key presses on the hit row are scored as hits.
- Notes that fall off the bottom unhit are counted as misses. A small FSM runs the game: idle, play, game over.
- Replaces the single-cell row light; the is10-style tick becomes a shift enable.

---
 rtl/ddr_note_field.sv | 186 ++++++++++++++++++
 tb/tb_ddr_note_field.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_note_field.sv
// ddr_note_field -- scrolling DDR playfield with hit/miss scoring.
//
// A LANES x ROWS grid of arrow lights. Row 0 is the top (notes spawn here),
// row ROWS-1 is the hit row. Each game tick scrolls the grid down one row;
// notes still lit in the hit row when it scrolls off are misses. Rising key
// edges on a lit hit-row lane score hits. A three-state FSM (IDLE/PLAY/OVER)
// gates all grid activity.
//
// Optional build macro: DDR_COMBO_EN adds o_combo (consecutive-hit counter);
// while combo >= 8 every hit lane scores 2 instead of 1.
//
// Ports:
//   i_clk      system clock
//   i_rst      asynchronous active-high reset
//   i_start    level; enters PLAY from IDLE or OVER (clears grid/score/misses)
//   i_tick     one-cycle scroll enable
//   i_spawn    notes inserted into row 0 on tick
//   i_keys     player buttons (synchronous levels)
//   o_lights   grid; bit r*LANES+l is row r, lane l
//   o_hit      pulse: at least one note hit last cycle
//   o_miss     pulse: at least one note lost last cycle
//   o_score    saturating hit score
//   o_misses   saturating miss count (0..15)
//   o_playing  high in PLAY
//   o_over     high in OVER
//   o_combo    (DDR_COMBO_EN only) consecutive-hit counter, saturates at 255
module ddr_note_field #(
    parameter int LANES    = 4,
    parameter int ROWS     = 8,
    parameter int SCORE_W  = 8,
    parameter int MAX_MISS = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_tick,
    input  logic [LANES-1:0]       i_spawn,
    input  logic [LANES-1:0]       i_keys,
    output logic [LANES*ROWS-1:0]  o_lights,
    output logic                   o_hit,
    output logic                   o_miss,
    output logic [SCORE_W-1:0]     o_score,
    output logic [3:0]             o_misses,
    output logic                   o_playing,
`ifdef DDR_COMBO_EN
    output logic                   o_over,
    output logic [7:0]             o_combo
`else
    output logic                   o_over
`endif
);

    localparam int CW    = $clog2(LANES + 1);   // popcount width
    localparam int SUM_W = SCORE_W + CW + 2;
    localparam int MS_W  = CW + 5;
    localparam logic [SCORE_W-1:0] LP_SCORE_MAX = '1;
    localparam logic [3:0]         LP_MAX_MISS  = 4'(MAX_MISS);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_t;

    state_t                        r_state, w_state_nxt;
    logic                          w_enter;
    logic [ROWS-1:0][LANES-1:0]    r_grid, w_grid_nxt;
    logic [LANES-1:0]              r_keys_q;
    logic                          r_hit, r_miss;
    logic [SCORE_W-1:0]            r_score;
    logic [3:0]                    r_misses;

    logic                          w_play;
    logic [LANES-1:0]              w_keyrise, w_hitrow, w_hitmask, w_lost;
    logic [CW-1:0]                 w_nhit, w_nlost;
    logic [CW:0]                   w_score_inc;
    logic [SUM_W-1:0]              w_score_sum;
    logic [SCORE_W-1:0]            w_score_nxt;
    logic [MS_W-1:0]               w_miss_sum;
    logic [3:0]                    w_misses_nxt;

    function automatic logic [CW-1:0] f_popcnt(input logic [LANES-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) c = c + CW'(v[i]);
        return c;
    endfunction

    // FSM next state; w_enter marks the cycle that (re)starts a game
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) begin w_state_nxt = S_PLAY; w_enter = 1'b1; end
            S_PLAY: if (r_misses >= LP_MAX_MISS) w_state_nxt = S_OVER;
            S_OVER: if (i_start) begin w_state_nxt = S_PLAY; w_enter = 1'b1; end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_play    = (r_state == S_PLAY);
    assign w_keyrise = i_keys & ~r_keys_q;
    assign w_hitrow  = r_grid[ROWS-1];
    // Hits are judged on the pre-shift hit row; a note hit this cycle is
    // removed from the lost set even if a tick scrolls it off.
    assign w_hitmask = w_play ? (w_keyrise & w_hitrow) : '0;
    assign w_lost    = (w_play && i_tick) ? (w_hitrow & ~w_hitmask) : '0;
    assign w_nhit    = f_popcnt(w_hitmask);
    assign w_nlost   = f_popcnt(w_lost);

    always_comb begin
        w_grid_nxt = r_grid;
        if (w_enter) begin
            w_grid_nxt = '0;
        end else if (w_play) begin
            if (i_tick) begin
                for (int r = ROWS-1; r > 0; r--) w_grid_nxt[r] = r_grid[r-1];
                w_grid_nxt[0] = i_spawn;
            end else begin
                w_grid_nxt[ROWS-1] = w_hitrow & ~w_hitmask;
            end
        end
    end

`ifdef DDR_COMBO_EN
    logic [7:0]     r_combo, w_combo_nxt;
    logic [CW+8:0]  w_combo_sum;

    assign w_score_inc = (r_combo >= 8'd8) ? {w_nhit, 1'b0} : {1'b0, w_nhit};
    assign w_combo_sum = (CW+9)'(r_combo) + (CW+9)'(w_nhit);
    always_comb begin
        w_combo_nxt = r_combo;
        if (|w_lost)                       w_combo_nxt = '0;
        else if (w_combo_sum > (CW+9)'(255)) w_combo_nxt = 8'd255;
        else                               w_combo_nxt = w_combo_sum[7:0];
    end
    assign o_combo = r_combo;
`else
    assign w_score_inc = {1'b0, w_nhit};
`endif

    assign w_score_sum  = SUM_W'(r_score) + SUM_W'(w_score_inc);
    assign w_score_nxt  = (w_score_sum > SUM_W'(LP_SCORE_MAX)) ? LP_SCORE_MAX
                                                               : w_score_sum[SCORE_W-1:0];
    assign w_miss_sum   = MS_W'(r_misses) + MS_W'(w_nlost);
    assign w_misses_nxt = (w_miss_sum > MS_W'(15)) ? 4'd15 : w_miss_sum[3:0];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_grid   <= '0;
            r_keys_q <= '0;
            r_hit    <= 1'b0;
            r_miss   <= 1'b0;
            r_score  <= '0;
            r_misses <= '0;
`ifdef DDR_COMBO_EN
            r_combo  <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_grid   <= w_grid_nxt;
            r_keys_q <= i_keys;
            r_hit    <= |w_hitmask;
            r_miss   <= |w_lost;
            if (w_enter) begin
                r_score  <= '0;
                r_misses <= '0;
`ifdef DDR_COMBO_EN
                r_combo  <= '0;
`endif
            end else if (w_play) begin
                r_score  <= w_score_nxt;
                r_misses <= w_misses_nxt;
`ifdef DDR_COMBO_EN
                r_combo  <= w_combo_nxt;
`endif
            end
        end
    end

    assign o_lights  = r_grid;
    assign o_hit     = r_hit;
    assign o_miss    = r_miss;
    assign o_score   = r_score;
    assign o_misses  = r_misses;
    assign o_playing = (r_state == S_PLAY);
    assign o_over    = (r_state == S_OVER);

endmodule

// File: tb/tb_ddr_note_field.sv
// Scoreboard bench for ddr_note_field (LANES=4, ROWS=8, SCORE_W=8, MAX_MISS=5).
// Stimulus pushes the expected hit/miss event (pulses, score, misses) before
// driving the causing cycle; a negedge monitor pops and compares whenever a
// pulse is presented. Directed spot checks cover grid/FSM state.
module tb_ddr_note_field;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_tick = 1'b0;
    logic [3:0]  i_spawn = '0;
    logic [3:0]  i_keys = '0;
    logic [31:0] o_lights;
    logic        o_hit, o_miss, o_playing, o_over;
    logic [7:0]  o_score;
    logic [3:0]  o_misses;
`ifdef DDR_COMBO_EN
    logic [7:0]  o_combo;
`endif

    ddr_note_field #(.LANES(4), .ROWS(8), .SCORE_W(8), .MAX_MISS(5)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_tick(i_tick),
        .i_spawn(i_spawn), .i_keys(i_keys), .o_lights(o_lights),
        .o_hit(o_hit), .o_miss(o_miss), .o_score(o_score), .o_misses(o_misses),
        .o_playing(o_playing),
`ifdef DDR_COMBO_EN
        .o_over(o_over), .o_combo(o_combo)
`else
        .o_over(o_over)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       hit;
        logic       miss;
        logic [7:0] score;
        logic [3:0] misses;
    } ev_t;

    ev_t sb[$];
    int  n_chk = 0;
    int  n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic exp_ev(input logic h, input logic m, input int s, input int ms);
        ev_t e;
        e.hit = h; e.miss = m; e.score = 8'(s); e.misses = 4'(ms);
        sb.push_back(e);
    endtask

    // Monitor: every presented pulse must match the next expected event.
    always @(negedge clk) begin
        if (!rst && (o_hit || o_miss)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_pulse", {30'd0, o_hit, o_miss}, 32'd0);
            end else begin
                ev_t e;
                e = sb.pop_front();
                chk("ev_hit",    32'(o_hit),    32'(e.hit));
                chk("ev_miss",   32'(o_miss),   32'(e.miss));
                chk("ev_score",  32'(o_score),  32'(e.score));
                chk("ev_misses", 32'(o_misses), 32'(e.misses));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic tick(input logic [3:0] sp);
        i_tick = 1'b1; i_spawn = sp; cyc(1); i_tick = 1'b0; i_spawn = '0;
    endtask

    task automatic fall(input int n);
        repeat (n) tick(4'b0000);
    endtask

    task automatic press(input logic [3:0] k);
        i_keys = k; cyc(1); i_keys = '0; cyc(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sc;
        int cm;

        // --- reset state ---
        cyc(3);
        chk("rst_lights",  o_lights, 32'd0);
        chk("rst_score",   32'(o_score), 32'd0);
        chk("rst_misses",  32'(o_misses), 32'd0);
        chk("rst_playing", 32'(o_playing), 32'd0);
        chk("rst_pulses",  {30'd0, o_hit, o_miss}, 32'd0);
        rst = 1'b0; cyc(1);
        // ticks in IDLE are ignored
        tick(4'b1111);
        chk("idle_frozen", o_lights, 32'd0);
        i_start = 1'b1; cyc(1); i_start = 1'b0;
        chk("start_playing", 32'(o_playing), 32'd1);

        // --- single note falls to hit row and is hit ---
        tick(4'b0001); fall(7);
        chk("note_at_bit28", o_lights, 32'h1000_0000);
        exp_ev(1, 0, 1, 0);
        i_keys = 4'b0001; cyc(1);
        chk("hit_score", 32'(o_score), 32'd1);
        chk("hit_cleared", o_lights, 32'd0);
        i_keys = '0; cyc(1);
        tick(4'b0000);
        chk("no_miss_after_hit", 32'(o_miss), 32'd0);

        // --- unhit note becomes a miss on the 8th tick after spawn ---
        tick(4'b0001); fall(7);
        exp_ev(0, 1, 1, 1);
        tick(4'b0000);
        chk("miss_pulse", 32'(o_miss), 32'd1);
        chk("miss_count", 32'(o_misses), 32'd1);

        // --- held key across two notes scores only the first ---
        tick(4'b0001); tick(4'b0001); fall(6);
        exp_ev(1, 0, 2, 1);
        i_keys = 4'b0001; cyc(1);
        tick(4'b0000);             // note2 enters hit row, key still held
        exp_ev(0, 1, 2, 2);
        tick(4'b0000);             // note2 lost
        i_keys = '0; cyc(1);
        chk("held_score",  32'(o_score), 32'd2);
        chk("held_misses", 32'(o_misses), 32'd2);

        // --- tick and keyrise same cycle on lane 2 ---
        tick(4'b0100); fall(7);
        exp_ev(1, 0, 3, 2);
        i_tick = 1'b1; i_keys = 4'b0100; cyc(1); i_tick = 1'b0;
        chk("same_cyc_misses", 32'(o_misses), 32'd2);
        chk("same_cyc_lights", o_lights, 32'd0);
        i_keys = '0; cyc(1);

        // --- simultaneous hits on lanes 0 and 3: one pulse, +2 ---
        tick(4'b1001); fall(7);
        exp_ev(1, 0, 5, 2);
        press(4'b1001);
        chk("dual_score", 32'(o_score), 32'd5);

        // --- keyrise on empty lane: no effect ---
        press(4'b0010);
        chk("empty_lane_score", 32'(o_score), 32'd5);

        // --- score saturation: 64 full rows, every lane hit ---
        sc = 5;
        cm = 3;
        for (int t = 1; t <= 71; t++) begin
            tick((t <= 64) ? 4'b1111 : 4'b0000);
            if (t >= 8) begin
`ifdef DDR_COMBO_EN
                sc = sc + ((cm >= 8) ? 8 : 4);
                cm = (cm + 4 > 255) ? 255 : cm + 4;
`else
                sc = sc + 4;
`endif
                if (sc > 255) sc = 255;
                exp_ev(1, 0, sc, 2);
                press(4'b1111);
            end
        end
        chk("sat_score", 32'(o_score), 32'd255);
        chk("sat_misses", 32'(o_misses), 32'd2);

        // --- three lost notes bring misses to 5 -> OVER ---
        tick(4'b0111); fall(7);
        exp_ev(0, 1, 255, 5);
        tick(4'b1000);
        chk("over_misses", 32'(o_misses), 32'd5);
        chk("over_still_play", 32'(o_playing), 32'd1);
        cyc(1);
        chk("over_flag", 32'(o_over), 32'd1);
        chk("over_not_playing", 32'(o_playing), 32'd0);
        chk("over_lights", o_lights, 32'h0000_0008);
        tick(4'b1111); tick(4'b1111);
        press(4'b1111);
        chk("over_frozen", o_lights, 32'h0000_0008);
        chk("over_score_held", 32'(o_score), 32'd255);

        // --- restart from OVER clears everything ---
        i_start = 1'b1; cyc(1); i_start = 1'b0;
        chk("restart_playing", 32'(o_playing), 32'd1);
        chk("restart_lights", o_lights, 32'd0);
        chk("restart_score", 32'(o_score), 32'd0);
        chk("restart_misses", 32'(o_misses), 32'd0);
`ifdef DDR_COMBO_EN
        chk("restart_combo", 32'(o_combo), 32'd0);
`endif

        // --- reset mid-game with a populated grid ---
        tick(4'b0011); fall(7);
        exp_ev(1, 0, 1, 0);
        press(4'b0001);
        chk("pre_rst_lights", o_lights, 32'h2000_0000);
        chk("pre_rst_score", 32'(o_score), 32'd1);
        rst = 1'b1; #1;
        chk("midrst_lights", o_lights, 32'd0);
        chk("midrst_score", 32'(o_score), 32'd0);
        chk("midrst_playing", 32'(o_playing), 32'd0);
        chk("midrst_pulses", {30'd0, o_hit, o_miss}, 32'd0);
        cyc(1); rst = 1'b0; cyc(1);
        i_start = 1'b1; cyc(1); i_start = 1'b0;
        chk("post_rst_playing", 32'(o_playing), 32'd1);

`ifdef DDR_COMBO_EN
        // --- combo: 8 hits then doubled scoring, miss clears ---
        for (int t = 1; t <= 16; t++) begin
            tick((t <= 9) ? 4'b0001 : 4'b0000);
            if (t >= 8) begin
                exp_ev(1, 0, (t - 7 <= 8) ? t - 7 : 10, 0);
                press(4'b0001);
                if (t == 15) begin
                    chk("combo_8", 32'(o_combo), 32'd8);
                    chk("combo_8_score", 32'(o_score), 32'd8);
                end
            end
        end
        chk("combo_9_score", 32'(o_score), 32'd10);
        tick(4'b0001); fall(7);
        exp_ev(0, 1, 10, 1);
        tick(4'b0000);
        chk("combo_cleared", 32'(o_combo), 32'd0);
`endif

        cyc(3);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
